alu_seq16: RTL and testbench

Sequences 16-bit register-pair arithmetic (ADD HL,rr; INC rr; DEC rr) onto the 8-bit Game Boy ALU by issuing two byte operations: low byte first, then high byte with carry. It sits between the control unit and the ALU, drives the ALU's operand and opcode inputs, and captures the ALU's result and flag outputs. It returns a 16-bit result and the updated flag byte to the control unit.

---
 rtl/gate_boy_pkg.sv | 23 ++
 rtl/alu_seq16_if.sv | 34 +++
 rtl/alu_seq16.sv | 169 ++++++++++++++++
 tb/tb_alu_seq16.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_boy_pkg.sv
// Shared Game Boy CPU constants: ALU byte width, flag bit positions and ALU opcodes.
package gate_boy_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  localparam int unsigned FLAG_Z = 7;
  localparam int unsigned FLAG_N = 6;
  localparam int unsigned FLAG_H = 5;
  localparam int unsigned FLAG_C = 4;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_ADC = 4'd2,
    ALU_SUB = 4'd3,
    ALU_SBC = 4'd4,
    ALU_AND = 4'd5,
    ALU_XOR = 4'd6,
    ALU_OR  = 4'd7,
    ALU_CP  = 4'd8
  } instruction_t;

endpackage

// File: rtl/alu_seq16_if.sv
// Bundles the control-unit request/response and 8-bit ALU connections of alu_seq16.
interface alu_seq16_if;
  import gate_boy_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [15:0]           req_a;
  logic [15:0]           req_b;
  logic [7:0]            req_flags;
  logic                  rsp_valid;
  logic [15:0]           rsp_result;
  logic [7:0]            rsp_flags;
  logic [DATA_WIDTH-1:0] alu_operand_a;
  logic [DATA_WIDTH-1:0] alu_operand_b;
  instruction_t          alu_opcode;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [7:0]            alu_flags;

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_flags, alu_result, alu_flags,
    output req_ready, rsp_valid, rsp_result, rsp_flags,
           alu_operand_a, alu_operand_b, alu_opcode
  );

  // Control unit plus ALU side.
  modport master (
    output req_valid, req_op, req_a, req_b, req_flags, alu_result, alu_flags,
    input  req_ready, rsp_valid, rsp_result, rsp_flags,
           alu_operand_a, alu_operand_b, alu_opcode
  );

endinterface

// File: rtl/alu_seq16.sv
// Splits 16-bit ADD/INC/DEC into low ADD + high ADC on the 8-bit ALU.
// Define ALU_SEQ16_DEC_EN to execute DEC16; otherwise op 10 behaves like the reserved op.
module alu_seq16
  import gate_boy_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq16_if.slave bus
);

  localparam int unsigned CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_INC = 2'b01;
`ifdef ALU_SEQ16_DEC_EN
  localparam logic [1:0] OP_DEC = 2'b10;
`endif

  typedef enum logic [2:0] {IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, DONE} state_t;

  state_t       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [15:0]  a_q, a_d;
  logic [15:0]  x_q, x_d;
  logic [7:0]   flags_q, flags_d;
  logic [7:0]   res_lo_q, res_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         req_ready_q, req_ready_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [15:0]  rsp_result_q, rsp_result_d;
  logic [7:0]   rsp_flags_q, rsp_flags_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  instruction_t alu_op_q, alu_op_d;
  logic [7:0]   add_flags;
  logic         wait_last;
  logic         unused_alu_flags;

  assign wait_last = (cnt_q == CNT_W'(ALU_LATENCY - 1));
  assign unused_alu_flags = ^{bus.alu_flags[FLAG_Z], bus.alu_flags[FLAG_N], bus.alu_flags[3:0]};

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    x_d          = x_q;
    flags_d      = flags_q;
    res_lo_d     = res_lo_q;
    cnt_d        = cnt_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;

    // ADD16 keeps Z, clears N and takes H/C from the high-byte ADC.
    add_flags         = '0;
    add_flags[FLAG_Z] = flags_q[FLAG_Z];
    add_flags[FLAG_N] = 1'b0;
    add_flags[FLAG_H] = bus.alu_flags[FLAG_H];
    add_flags[FLAG_C] = bus.alu_flags[FLAG_C];

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          op_d    = bus.req_op;
          a_d     = bus.req_a;
          flags_d = bus.req_flags;
          case (bus.req_op)
            OP_ADD: begin x_d = bus.req_b; state_d = ISSUE_LO; end
            OP_INC: begin x_d = 16'h0001;  state_d = ISSUE_LO; end
`ifdef ALU_SEQ16_DEC_EN
            OP_DEC: begin x_d = 16'hFFFF;  state_d = ISSUE_LO; end
`endif
            default: begin
              state_d      = DONE;
              rsp_result_d = bus.req_a;
              rsp_flags_d  = bus.req_flags;
            end
          endcase
        end
      end
      ISSUE_LO: begin
        cnt_d   = '0;
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (wait_last) begin
          res_lo_d = bus.alu_result;
          state_d  = ISSUE_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ISSUE_HI: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (wait_last) begin
          rsp_result_d = {bus.alu_result, res_lo_q};
          rsp_flags_d  = (op_q == OP_ADD) ? add_flags : flags_q;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
    alu_op_d    = ALU_NOP;
    alu_a_d     = '0;
    alu_b_d     = '0;
    if (state_d == ISSUE_LO || state_d == WAIT_LO) begin
      alu_op_d = ALU_ADD;
      alu_a_d  = a_d[7:0];
      alu_b_d  = x_d[7:0];
    end else if (state_d == ISSUE_HI || state_d == WAIT_HI) begin
      alu_op_d = ALU_ADC;
      alu_a_d  = a_d[15:8];
      alu_b_d  = x_d[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      x_q          <= '0;
      flags_q      <= '0;
      res_lo_q     <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= ALU_NOP;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      x_q          <= x_d;
      flags_q      <= flags_d;
      res_lo_q     <= res_lo_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_result    = rsp_result_q;
  assign bus.rsp_flags     = rsp_flags_q;
  assign bus.alu_operand_a = alu_a_q;
  assign bus.alu_operand_b = alu_b_q;
  assign bus.alu_opcode    = alu_op_q;

endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16: two instances (ALU latency 1 and 3) with behavioural GB ALU models.
module tb_alu_seq16;
  import gate_boy_pkg::*;

  localparam int unsigned L_A = 1;
  localparam int unsigned L_B = 3;
`ifdef ALU_SEQ16_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  f;
    logic [15:0] res;
    logic [7:0]  flags;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [7:0]  flags;
    int unsigned done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          unstable = 0;
  exp_t        sb_a[$];
  exp_t        sb_b[$];
  instruction_t prev_op[2] = '{ALU_NOP, ALU_NOP};
  logic [7:0]  prev_oa[2] = '{8'h00, 8'h00};
  logic [7:0]  prev_ob[2] = '{8'h00, 8'h00};
  vec_t        vecs[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq16_if bus_a ();
  alu_seq16_if bus_b ();

  alu_seq16 #(.ALU_LATENCY(L_A)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  alu_seq16 #(.ALU_LATENCY(L_B)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Game Boy ADD/ADC: returns {flags, result}.
  function automatic logic [15:0] alu_eval(input instruction_t op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
    logic [8:0] s;
    logic [4:0] h;
    logic       ci;
    if (op != ALU_ADD && op != ALU_ADC) return 16'h0000;
    ci = (op == ALU_ADC) ? cin : 1'b0;
    s  = {1'b0, a} + {1'b0, b} + {8'b0, ci};
    h  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, ci};
    return {(s[7:0] == 8'h00), 1'b0, h[4], s[8], 4'b0000, s[7:0]};
  endfunction

  // ALU models: carry register updated by ADD only, result delayed by the latency.
  logic [15:0] ev_a, ev_b;
  logic        c_a, c_b;
  logic [15:0] pipe_a[L_A];
  logic [15:0] pipe_b[L_B];

  assign ev_a = alu_eval(bus_a.alu_opcode, bus_a.alu_operand_a, bus_a.alu_operand_b, c_a);
  assign ev_b = alu_eval(bus_b.alu_opcode, bus_b.alu_operand_a, bus_b.alu_operand_b, c_b);

  always @(posedge clk) begin
    if (!rst_n) begin
      c_a <= 1'b0;
      for (int i = 0; i < int'(L_A); i++) pipe_a[i] <= 16'h0;
    end else begin
      if (bus_a.alu_opcode == ALU_ADD) c_a <= ev_a[12];
      pipe_a[0] <= ev_a;
      for (int i = 1; i < int'(L_A); i++) pipe_a[i] <= pipe_a[i-1];
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      c_b <= 1'b0;
      for (int j = 0; j < int'(L_B); j++) pipe_b[j] <= 16'h0;
    end else begin
      if (bus_b.alu_opcode == ALU_ADD) c_b <= ev_b[12];
      pipe_b[0] <= ev_b;
      for (int j = 1; j < int'(L_B); j++) pipe_b[j] <= pipe_b[j-1];
    end
  end

  assign bus_a.alu_result = pipe_a[L_A-1][7:0];
  assign bus_a.alu_flags  = pipe_a[L_A-1][15:8];
  assign bus_b.alu_result = pipe_b[L_B-1][7:0];
  assign bus_b.alu_flags  = pipe_b[L_B-1][15:8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor and ALU input stability tracking for instance i.
  task automatic mon(input int i, input logic v, input logic [15:0] r, input logic [7:0] f,
                     input instruction_t op, input logic [7:0] oa, input logic [7:0] ob);
    exp_t e;
    int   depth;
    if (op != ALU_NOP && op == prev_op[i] && (oa != prev_oa[i] || ob != prev_ob[i])) unstable++;
    if (op == ALU_ADC && prev_op[i] != ALU_ADD && prev_op[i] != ALU_ADC) unstable++;
    prev_op[i] = op;
    prev_oa[i] = oa;
    prev_ob[i] = ob;
    if (v) begin
      depth = (i == 0) ? sb_a.size() : sb_b.size();
      if (depth == 0) begin
        chk("unexpected_rsp_valid", 32'(v), 32'd0);
      end else begin
        if (i == 0) e = sb_a.pop_front();
        else        e = sb_b.pop_front();
        chk("rsp_result", 32'(r), 32'(e.res));
        chk("rsp_flags", 32'(f), 32'(e.flags));
        chk("rsp_cycle", cyc, e.done);
        chk("alu_idle_in_done", 32'({op, oa, ob}), 32'd0);
      end
    end
  endtask

  always @(negedge clk) mon(0, bus_a.rsp_valid, bus_a.rsp_result, bus_a.rsp_flags,
                            bus_a.alu_opcode, bus_a.alu_operand_a, bus_a.alu_operand_b);
  always @(negedge clk) mon(1, bus_b.rsp_valid, bus_b.rsp_result, bus_b.rsp_flags,
                            bus_b.alu_opcode, bus_b.alu_operand_a, bus_b.alu_operand_b);

  task automatic drive(input int i, input logic v, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [7:0] f);
    if (i == 0) begin
      bus_a.req_valid = v; bus_a.req_op = op; bus_a.req_a = a; bus_a.req_b = b; bus_a.req_flags = f;
    end else begin
      bus_b.req_valid = v; bus_b.req_op = op; bus_b.req_a = a; bus_b.req_b = b; bus_b.req_flags = f;
    end
  endtask

  function automatic logic ready(input int i);
    return (i == 0) ? bus_a.req_ready : bus_b.req_ready;
  endfunction

  // Present a request, wait for acceptance, push the expected response.
  task automatic send(input int i, input vec_t v, input bit hold, output int unsigned acc);
    exp_t        e;
    int unsigned lat;
    bit          seq;
    int          n;
    lat = (i == 0) ? L_A : L_B;
    seq = (v.op == 2'b00) || (v.op == 2'b01) || (v.op == 2'b10 && DEC_EN);
    @(negedge clk);
    drive(i, 1'b1, v.op, v.a, v.b, v.f);
    n = 0;
    while (!ready(i) && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = 0;
    if (!ready(i)) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      drive(i, 1'b0, 2'b00, 16'h0, 16'h0, 8'h0);
      return;
    end
    e.res   = v.res;
    e.flags = v.flags;
    e.done  = cyc + (seq ? (3 + 2 * lat) : 1);
    if (i == 0) sb_a.push_back(e);
    else        sb_b.push_back(e);
    acc = cyc + 1;
    @(posedge clk);
    #1;
    if (!hold) drive(i, 1'b0, 2'b00, 16'h0, 16'h0, 8'h0);
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (((i == 0) ? sb_a.size() : sb_b.size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (((i == 0) ? sb_a.size() : sb_b.size()) != 0) begin
      chk("drain_timeout", 32'((i == 0) ? sb_a.size() : sb_b.size()), 32'd0);
      if (i == 0) sb_a.delete();
      else        sb_b.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc, acc1, acc2;
    vec_t        v;

    vecs[0] = '{2'b00, 16'h0FFF, 16'h0001, 8'h80, 16'h1000, 8'hA0};
    vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h30};
    vecs[2] = '{2'b01, 16'h00FF, 16'h0000, 8'hF0, 16'h0100, 8'hF0};
    vecs[3] = '{2'b10, 16'h0000, 16'h0000, 8'h50, (DEC_EN ? 16'hFFFF : 16'h0000), 8'h50};
    vecs[4] = '{2'b11, 16'h1234, 16'h5555, 8'h10, 16'h1234, 8'h10};
    vecs[5] = '{2'b00, 16'h8000, 16'h8000, 8'h40, 16'h0000, 8'h10};
    vecs[6] = '{2'b00, 16'h1234, 16'h0FCD, 8'hC0, 16'h2201, 8'hA0};

    drive(0, 1'b0, 2'b00, 16'h0, 16'h0, 8'h0);
    drive(1, 1'b0, 2'b00, 16'h0, 16'h0, 8'h0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(bus_a.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    chk("reset_rsp", 32'({bus_a.rsp_result, bus_a.rsp_flags}), 32'd0);
    chk("reset_alu_opcode", 32'(bus_b.alu_opcode), 32'(ALU_NOP));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset_a", 32'(bus_a.req_ready), 32'd1);
    chk("ready_after_reset_b", 32'(bus_b.req_ready), 32'd1);

    // Table-driven single requests on the latency-1 instance.
    for (int k = 0; k < 7; k++) begin
      send(0, vecs[k], 1'b0, acc);
      @(negedge clk);
      chk("ready_low_after_accept", 32'(bus_a.req_ready), 32'd0);
      drain(0);
    end

    // Latency 3, req_valid held across two back-to-back ADD16 requests.
    send(1, vecs[0], 1'b1, acc1);
    send(1, vecs[1], 1'b0, acc2);
    chk("b2b_accept_gap", acc2 - acc1, 32'd10);
    drain(1);
    send(1, vecs[2], 1'b0, acc);
    drain(1);

    // Reset during WAIT_HI discards the in-flight request.
    send(0, vecs[0], 1'b0, acc);
    repeat (4) @(negedge clk);
    chk("in_wait_hi_opcode", 32'(bus_a.alu_opcode), 32'(ALU_ADC));
    rst_n = 1'b0;
    sb_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    chk("midreset_rsp", 32'({bus_a.rsp_result, bus_a.rsp_flags}), 32'd0);
    chk("midreset_alu", 32'({bus_a.alu_opcode, bus_a.alu_operand_a, bus_a.alu_operand_b}), 32'd0);
    @(negedge clk);
    chk("midreset_ready", 32'(bus_a.req_ready), 32'd1);
    repeat (8) @(negedge clk);
    v = vecs[6];
    send(0, v, 1'b0, acc);
    drain(0);

    chk("alu_inputs_stable", 32'(unstable), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
